regfile_sb: RTL and testbench

Parametrised successor to the CPU's 32x32 integer register file. It provides two combinational read ports, one synchronous write port, a hardwired-zero register 0 and a per-register pending-write scoreboard for the decode stage's hazard detection. After reset, a clear sequencer zeroes the architectural registers, one per cycle. The block sits between decode (read, issue) and writeback (write).

---
 rtl/regfile_sb.sv | 134 +++++++++++++
 tb/tb_regfile_sb.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_sb
//  Purpose  : Parametrised integer register file with two combinational read
//             ports, one synchronous write port, hardwired-zero register 0,
//             a per-register pending-write scoreboard and a post-reset clear
//             sequencer that zeroes registers 1..NREG-1, one per cycle.
//  Option   : define REGFILE_SB_BYPASS_EN for same-cycle write-through
//             forwarding of read data and busy clearing.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_sb #(
   parameter int XLEN = 32,
   parameter int AW   = 5,
   parameter int NREG = 2**AW
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   ra1,
   input  logic [AW-1:0]   ra2,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2,
   input  logic            we,
   input  logic [AW-1:0]   wa,
   input  logic [XLEN-1:0] wd,
   input  logic            iss_valid,
   input  logic [AW-1:0]   iss_rd,
   input  logic            flush,
   output logic            busy1,
   output logic            busy2,
   output logic            ready
);

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   // NREG is always 2**AW, so the last register address is all ones.
   localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

   state_t          state;
   state_t          state_nxt;
   logic [AW-1:0]   ptr;
   logic [XLEN-1:0] regs [NREG];
   logic [NREG-1:0] pend;
   logic [NREG-1:0] pend_nxt;
   logic            run;
   logic            wr_en;
   logic            fwd1;
   logic            fwd2;

   assign run   = (state == RUN);
   assign wr_en = run && we && (wa != '0);
   assign ready = run;

   // State register; any reset (including mid-clear) restarts the sequencer.
   always_ff @(posedge clk) begin
      if (!rst) state <= CLEAR;
      else      state <= state_nxt;
   end

   // Next state: leave CLEAR once the last register has been zeroed.
   always_comb begin
      state_nxt = state;
      case (state)
         CLEAR:   if (ptr == LAST_ADDR) state_nxt = RUN;
         RUN:     state_nxt = RUN;
         default: state_nxt = CLEAR;
      endcase
   end

   // Clear pointer; register 0 is never stored, so clearing starts at 1.
   always_ff @(posedge clk) begin
      if (!rst)                ptr <= {{(AW-1){1'b0}}, 1'b1};
      else if (state == CLEAR) ptr <= ptr + 1'b1;
   end

   // Register array: zeroed by the sequencer, then written by writeback.
   always_ff @(posedge clk) begin
      if (rst) begin
         if (state == CLEAR) regs[ptr] <= '0;
         else if (wr_en)     regs[wa]  <= wd;
      end
   end

   // Scoreboard update: flush beats issue, issue beats writeback.
   always_comb begin
      pend_nxt = pend;
      if (run) begin
         if (we)        pend_nxt[wa]     = 1'b0;
         if (iss_valid) pend_nxt[iss_rd] = 1'b1;
         if (flush)     pend_nxt         = '0;
      end
      pend_nxt[0] = 1'b0;
   end

   // Pending bits register.
   always_ff @(posedge clk) begin
      if (!rst) pend <= '0;
      else      pend <= pend_nxt;
   end

`ifdef REGFILE_SB_BYPASS_EN
   // A same-cycle write to the read address is forwarded straight through.
   assign fwd1 = wr_en && (wa == ra1);
   assign fwd2 = wr_en && (wa == ra2);
`else
   assign fwd1 = 1'b0;
   assign fwd2 = 1'b0;
`endif

   // Read port 1: zero during clear and for register 0.
   always_comb begin
      rd1   = '0;
      busy1 = 1'b0;
      if (run && (ra1 != '0)) begin
         rd1   = fwd1 ? wd   : regs[ra1];
         busy1 = fwd1 ? 1'b0 : pend[ra1];
      end
   end

   // Read port 2: zero during clear and for register 0.
   always_comb begin
      rd2   = '0;
      busy2 = 1'b0;
      if (run && (ra2 != '0)) begin
         rd2   = fwd2 ? wd   : regs[ra2];
         busy2 = fwd2 ? 1'b0 : pend[ra2];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_sb
//  Purpose  : Self-checking bench for regfile_sb. Expected output values are
//             queued as each cycle's stimulus is driven and compared against
//             the DUT on the following falling edge.
//  Option   : honours REGFILE_SB_BYPASS_EN for the forwarding expectations.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_regfile_sb;
   localparam int XLEN = 32;
   localparam int AW   = 5;
`ifdef REGFILE_SB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   localparam int S_RD1 = 0, S_RD2 = 1, S_B1 = 2, S_B2 = 3, S_RDY = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [AW-1:0]   ra1, ra2, wa, iss_rd;
   logic [XLEN-1:0] rd1, rd2, wd;
   logic            we, iss_valid, flush, busy1, busy2, ready;

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] val;
   } exp_t;

   exp_t sbq[$];
   int   total = 0;
   int   bad   = 0;

   regfile_sb #(.XLEN(XLEN), .AW(AW)) dut (
      .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
      .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid), .iss_rd(iss_rd),
      .flush(flush), .busy1(busy1), .busy2(busy2), .ready(ready)
   );

   always #5 clk = ~clk;

   // Single comparison point: counts and reports mismatches.
   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", tag, got, exp);
      end
   endtask

   task automatic expect_out(input string tag, input int sel, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.val = val;
      sbq.push_back(e);
   endtask

   function automatic logic [31:0] observe(input int sel);
      case (sel)
         S_RD1:   return rd1;
         S_RD2:   return rd2;
         S_B1:    return {31'b0, busy1};
         S_B2:    return {31'b0, busy2};
         default: return {31'b0, ready};
      endcase
   endfunction

   // Compare this cycle's queued expectations at negedge, then advance.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         check_val(e.tag, observe(e.sel), e.val);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we = 1'b0; iss_valid = 1'b0; flush = 1'b0;
   endtask

   initial begin
      rst = 1'b0; ra1 = '0; ra2 = '0; wa = '0; wd = '0; iss_rd = '0;
      idle();
      @(posedge clk);
      #1;
      // Reset held: outputs quiet.
      for (int i = 0; i < 2; i++) begin
         ra1 = 5'd5;
         expect_out("rst_ready", S_RDY, 0);
         expect_out("rst_rd1", S_RD1, 0);
         expect_out("rst_busy1", S_B1, 0);
         tick();
      end

      // Clear sequence with writes and issues that must be dropped.
      rst = 1'b1; we = 1'b1; wa = 5'd5; wd = 32'hFFFF_FFFF;
      iss_valid = 1'b1; iss_rd = 5'd6; ra1 = 5'd5; ra2 = 5'd6;
      for (int k = 0; k < 31; k++) begin
         expect_out("clr_ready", S_RDY, 0);
         expect_out("clr_rd1", S_RD1, 0);
         expect_out("clr_busy2", S_B2, 0);
         tick();
      end
      idle();
      for (int i = 0; i < 16; i++) begin
         ra1 = 5'(2 * i); ra2 = 5'(2 * i + 1);
         expect_out("run_ready", S_RDY, 1);
         expect_out("zero_rd1", S_RD1, 0);
         expect_out("zero_rd2", S_RD2, 0);
         expect_out("zero_busy1", S_B1, 0);
         expect_out("zero_busy2", S_B2, 0);
         tick();
      end

      // Write r5, read next cycle; same cycle shows old value unless forwarded.
      we = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF; ra1 = 5'd5;
      expect_out("wr5_same", S_RD1, BYP ? 32'hDEAD_BEEF : 32'h0);
      tick();
      idle();
      expect_out("wr5_next", S_RD1, 32'hDEAD_BEEF);
      tick();

      // Writes to r0 are discarded.
      we = 1'b1; wa = 5'd0; wd = 32'h1234; ra2 = 5'd0;
      expect_out("wr0_same", S_RD2, 0);
      tick();
      idle();
      expect_out("wr0_next", S_RD2, 0);
      tick();

      // Write r12 with a read of the same address in the same cycle.
      we = 1'b1; wa = 5'd12; wd = 32'hA5A5_A5A5; ra1 = 5'd12;
      expect_out("byp_rd1", S_RD1, BYP ? 32'hA5A5_A5A5 : 32'h0);
      expect_out("byp_busy1", S_B1, 0);
      tick();
      idle();
      expect_out("wr12_next", S_RD1, 32'hA5A5_A5A5);
      tick();

      // Scoreboard: issue r9, then writeback r9.
      iss_valid = 1'b1; iss_rd = 5'd9; ra1 = 5'd9;
      expect_out("iss9_same", S_B1, 0);
      tick();
      idle();
      expect_out("iss9_next", S_B1, 1);
      tick();
      we = 1'b1; wa = 5'd9; wd = 32'd77;
      expect_out("wb9_same", S_B1, BYP ? 0 : 1);
      tick();
      idle();
      expect_out("wb9_next", S_B1, 0);
      expect_out("wb9_data", S_RD1, 32'd77);
      tick();
      // Issue and writeback to r9 in the same cycle: issue wins.
      iss_valid = 1'b1; iss_rd = 5'd9; we = 1'b1; wa = 5'd9; wd = 32'd88;
      expect_out("both9_same", S_B1, 0);
      tick();
      idle();
      expect_out("both9_busy", S_B1, 1);
      expect_out("both9_data", S_RD1, 32'd88);
      tick();
      we = 1'b1; wa = 5'd9; wd = 32'd99;
      tick();
      idle();
      expect_out("wb9b_next", S_B1, 0);
      tick();

      // Flush beats a same-cycle issue.
      iss_valid = 1'b1; iss_rd = 5'd3;  tick();
      iss_rd = 5'd7;  tick();
      iss_rd = 5'd31; tick();
      idle(); ra1 = 5'd3; ra2 = 5'd7;
      expect_out("pend3", S_B1, 1);
      expect_out("pend7", S_B2, 1);
      tick();
      ra1 = 5'd31;
      flush = 1'b1; iss_valid = 1'b1; iss_rd = 5'd4;
      expect_out("pend31", S_B1, 1);
      tick();
      idle(); ra1 = 5'd3; ra2 = 5'd7;
      expect_out("fl_b3", S_B1, 0);
      expect_out("fl_b7", S_B2, 0);
      tick();
      ra1 = 5'd31; ra2 = 5'd4;
      expect_out("fl_b31", S_B1, 0);
      expect_out("fl_b4", S_B2, 0);
      tick();

      // Leave r20 pending, then reset from RUN and again at ptr=10.
      iss_valid = 1'b1; iss_rd = 5'd20; tick();
      idle(); rst = 1'b0; tick();
      expect_out("rr_ready0", S_RDY, 0);
      rst = 1'b1;
      for (int k = 0; k < 9; k++) begin
         expect_out("rr_clr_ready", S_RDY, 0);
         tick();
      end
      rst = 1'b0;
      expect_out("mid_ready", S_RDY, 0);
      tick();
      rst = 1'b1;
      for (int k = 0; k < 31; k++) begin
         expect_out("mid_clr_ready", S_RDY, 0);
         tick();
      end
      ra1 = 5'd5; ra2 = 5'd20;
      expect_out("mid_ready1", S_RDY, 1);
      expect_out("mid_r5_zero", S_RD1, 0);
      expect_out("mid_b20", S_B2, 0);
      expect_out("mid_r20_zero", S_RD2, 0);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
